// File: rtl/window_sequencer_if.sv
// rtl/window_sequencer_if.sv - handshake and position bundle for window_sequencer (sof only with WINDOW_SEQ_SOF_RESYNC_EN)
interface window_sequencer_if #(
    parameter int FrameWidth  = 640,
    parameter int FrameHeight = 480
);
    localparam int ColWidth = (FrameWidth  > 1) ? $clog2(FrameWidth)  : 1;
    localparam int RowWidth = (FrameHeight > 1) ? $clog2(FrameHeight) : 1;

    logic                up_valid;
    logic                up_ready;
    logic                dn_valid;
    logic                dn_ready;
    logic [ColWidth-1:0] col;
    logic [RowWidth-1:0] row;
    logic                eol;
    logic                eof;
    logic                busy;
    logic                frame_done;
`ifdef WINDOW_SEQ_SOF_RESYNC_EN
    logic                sof;

    modport slave (
        input  up_valid, dn_ready, sof,
        output up_ready, dn_valid, col, row, eol, eof, busy, frame_done
    );
    modport master (
        output up_valid, dn_ready, sof,
        input  up_ready, dn_valid, col, row, eol, eof, busy, frame_done
    );
`else
    modport slave (
        input  up_valid, dn_ready,
        output up_ready, dn_valid, col, row, eol, eof, busy, frame_done
    );
    modport master (
        output up_valid, dn_ready,
        input  up_ready, dn_valid, col, row, eol, eof, busy, frame_done
    );
`endif
endinterface

// File: rtl/window_sequencer.sv
// rtl/window_sequencer.sv - frame position tracker; sinks priming beats, forwards full-window beats (option: WINDOW_SEQ_SOF_RESYNC_EN)
module window_sequencer #(
    parameter int FrameWidth   = 640,
    parameter int FrameHeight  = 480,
    parameter int KernelWidth  = 3,
    parameter int KernelHeight = 3
) (
    input logic             clk_i,
    input logic             rst_ni,
    window_sequencer_if.slave bus
);
    localparam int ColWidth = (FrameWidth  > 1) ? $clog2(FrameWidth)  : 1;
    localparam int RowWidth = (FrameHeight > 1) ? $clog2(FrameHeight) : 1;
    localparam logic [ColWidth-1:0] ColLast = ColWidth'(FrameWidth - 1);
    localparam logic [RowWidth-1:0] RowLast = RowWidth'(FrameHeight - 1);
    localparam logic [ColWidth-1:0] ColWin  = ColWidth'(KernelWidth - 1);
    localparam logic [RowWidth-1:0] RowWin  = RowWidth'(KernelHeight - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nxt;
    logic [ColWidth-1:0] col_r;
    logic [RowWidth-1:0] row_r;
    logic [ColWidth-1:0] col_eff;
    logic [RowWidth-1:0] row_eff;
    logic [ColWidth-1:0] col_nxt;
    logic [RowWidth-1:0] row_nxt;
    logic                frame_done_r;
    logic                sof_hit;
    logic                win;
    logic                eol;
    logic                eof;
    logic                fire;
    logic                promote;

`ifdef WINDOW_SEQ_SOF_RESYNC_EN
    assign sof_hit = bus.up_valid & bus.sof;
`else
    assign sof_hit = 1'b0;
`endif

    // A resync beat is classified as (0,0) in the same cycle it is presented
    always_comb begin
        col_eff = sof_hit ? '0 : col_r;
        row_eff = sof_hit ? '0 : row_r;
        win     = (row_eff >= RowWin) && (col_eff >= ColWin);
        eol     = (col_eff == ColLast);
        eof     = eol && (row_eff == RowLast);
        fire    = bus.up_valid && (win ? bus.dn_ready : 1'b1);
    end

    always_comb begin
        col_nxt = col_r;
        row_nxt = row_r;
        if (fire) begin
            if (eof) begin
                col_nxt = '0;
                row_nxt = '0;
            end else if (eol) begin
                col_nxt = '0;
                row_nxt = row_eff + 1'b1;
            end else begin
                col_nxt = col_eff + 1'b1;
                row_nxt = row_eff;
            end
        end
        promote = (row_nxt >= RowWin);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r      <= IDLE;
            col_r        <= '0;
            row_r        <= '0;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_nxt;
            col_r        <= col_nxt;
            row_r        <= row_nxt;
            frame_done_r <= fire & eof;
        end
    end

    // eof returns to IDLE from any state, which also covers the 1-row degenerate frame
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            IDLE: begin
                if (fire) state_nxt = eof ? IDLE : (promote ? ACTIVE : PRIME);
            end
            PRIME: begin
                if (fire) state_nxt = eof ? IDLE : (promote ? ACTIVE : PRIME);
            end
            ACTIVE: begin
                if (fire) state_nxt = eof ? IDLE : (promote ? ACTIVE : PRIME);
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.dn_valid   = bus.up_valid & win;
        bus.up_ready   = win ? bus.dn_ready : 1'b1;
        bus.col        = col_eff;
        bus.row        = row_eff;
        bus.eol        = eol;
        bus.eof        = eof;
        bus.busy       = (state_r != IDLE);
        bus.frame_done = frame_done_r;
    end
endmodule
